// File: rtl/hack_mem_responder.sv
// Hack data memory map: RAM, SCREEN and KBD behind a 1-cycle read port,
// with the single-ported SCREEN shared between the CPU and a video reader.
module hack_mem_responder #(
  parameter int KBD_SYNC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic        writeM,
  input  logic [15:0] outM,
  output logic [15:0] inM,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_data,
  input  logic [15:0] kbd_code,
  output logic [7:0]  bad_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    VID_RD,
    VID_DONE
  } arbState_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_SCR,
    SEL_KBD
  } rdSel_t;

  logic isRam;
  logic isScr;
  logic isKbd;
  logic isBad;

  assign isRam = ~addressM[14];
  assign isScr = addressM[14:13] == 2'b10;
  assign isKbd = addressM == 15'h6000;
  assign isBad = (addressM[14:13] == 2'b11) && !isKbd;

  logic ramWe;
  logic scrWe;

  assign ramWe = reset && writeM && isRam;
  assign scrWe = reset && writeM && isScr;

  logic [15:0] ram [16384];
  logic [15:0] ramQ;

  always_ff @(posedge clk) begin
    if (ramWe) ram[addressM[13:0]] <= outM;
    ramQ <= ramWe ? outM : ram[addressM[13:0]];
  end

  // CPU owns the screen port whenever it addresses SCREEN.
  logic [15:0] screen [8192];
  logic [12:0] scrAddr;
  logic [15:0] scrQ;

  assign scrAddr = isScr ? addressM[12:0] : vid_addr;

  always_ff @(posedge clk) begin
    if (scrWe) screen[scrAddr] <= outM;
    scrQ <= scrWe ? outM : screen[scrAddr];
  end

  logic [15:0] kbdSync [KBD_SYNC];
  logic [15:0] kbdQ;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < KBD_SYNC; i++) kbdSync[i] <= '0;
    end else begin
      kbdSync[0] <= kbd_code;
      for (int i = 1; i < KBD_SYNC; i++) kbdSync[i] <= kbdSync[i-1];
    end
  end

  always_ff @(posedge clk) begin
    kbdQ <= kbdSync[KBD_SYNC-1];
  end

  rdSel_t rdSel;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdSel <= SEL_NONE;
    end else begin
      unique case (1'b1)
        isRam:   rdSel <= SEL_RAM;
        isScr:   rdSel <= SEL_SCR;
        isKbd:   rdSel <= SEL_KBD;
        default: rdSel <= SEL_NONE;
      endcase
    end
  end

  always_comb begin
    inM = '0;
    unique case (rdSel)
      SEL_RAM: inM = ramQ;
      SEL_SCR: inM = scrQ;
      SEL_KBD: inM = kbdQ;
      default: inM = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bad_cnt <= '0;
    end else if (isBad && bad_cnt != 8'hFF) begin
      bad_cnt <= bad_cnt + 8'd1;
    end
  end

  arbState_t state;
  arbState_t nextState;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= nextState;
  end

  // A CPU screen access in VID_RD steals the port, so the read repeats.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (vid_req && !isScr) nextState = VID_RD;
      end
      VID_RD: begin
        if (!vid_req) nextState = IDLE;
        else if (!isScr) nextState = VID_DONE;
      end
      VID_DONE: nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  assign vid_ack = state == VID_DONE;

  logic [15:0] vidHold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vidHold <= '0;
    end else if (state == VID_DONE) begin
      vidHold <= scrQ;
    end
  end

  assign vid_data = (state == VID_DONE) ? scrQ : vidHold;

endmodule

// File: tb/tb_hack_mem_responder.sv
// Directed bench for hack_mem_responder with a memory-map model
// checked every cycle plus hand-computed spot checks.
module tb_hack_mem_responder;

  localparam int K = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] addressM;
  logic        writeM;
  logic [15:0] outM;
  logic [15:0] inM;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_data;
  logic [15:0] kbd_code;
  logic [7:0]  bad_cnt;

  hack_mem_responder #(.KBD_SYNC(K)) dut (
    .clk(clk),
    .reset(reset),
    .addressM(addressM),
    .writeM(writeM),
    .outM(outM),
    .inM(inM),
    .vid_req(vid_req),
    .vid_addr(vid_addr),
    .vid_ack(vid_ack),
    .vid_data(vid_data),
    .kbd_code(kbd_code),
    .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  logic [15:0] ramM [int];
  logic [15:0] scrM [int];
  logic [15:0] kHist [64];
  int          edgeN = 0;
  int          lastRst = -100;
  logic [15:0] expInM = '0;
  bit          expValid = 1'b0;
  int          expBad = 0;
  logic [15:0] expVid = '0;
  bit          reqEdge = 1'b0;
  bit          rstEdge = 1'b0;
  int          vaddrEdge = 0;
  bit          acked = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic modelStep();
    int a;
    int o;
    a = int'(addressM);
    edgeN++;
    rstEdge = reset;
    reqEdge = vid_req;
    vaddrEdge = int'(vid_addr);
    if (!reset) begin
      lastRst = edgeN;
      expInM = '0;
      expValid = 1'b1;
      expBad = 0;
    end else if (a < 'h4000) begin
      if (writeM) ramM[a] = outM;
      expValid = ramM.exists(a);
      if (expValid) expInM = ramM[a];
    end else if (a < 'h6000) begin
      o = a - 'h4000;
      if (writeM) scrM[o] = outM;
      expValid = scrM.exists(o);
      if (expValid) expInM = scrM[o];
    end else if (a == 'h6000) begin
      expValid = 1'b1;
      expInM = (edgeN - K <= lastRst) ? 16'h0 : kHist[(edgeN - K) % 64];
    end else begin
      expValid = 1'b1;
      expInM = '0;
      if (expBad < 255) expBad++;
    end
    kHist[edgeN % 64] = kbd_code;
  endtask

  task automatic compareStep();
    if (expValid) chk("inM", 32'(inM), 32'(expInM));
    chk("bad_cnt", 32'(bad_cnt), expBad);
    if (!reqEdge || !rstEdge) acked = 1'b0;
    if (!rstEdge) expVid = '0;
    if (vid_ack) begin
      chk("ack_legal", {29'd0, rstEdge, reqEdge, acked}, 32'b110);
      acked = 1'b1;
      if (scrM.exists(vaddrEdge)) expVid = scrM[vaddrEdge];
    end
    chk("vid_data", 32'(vid_data), 32'(expVid));
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(posedge clk);
    #2;
    compareStep();
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic cpu(input logic [14:0] a, input logic we,
                     input logic [15:0] d);
    addressM = a;
    writeM = we;
    outM = d;
  endtask

  bit sawAck;
  int n;

  initial begin
    reset = 1'b0;
    vid_req = 1'b0;
    vid_addr = '0;
    kbd_code = '0;
    cpu(15'h0, 1'b0, 16'h0);
    repeat (3) tick();
    chk("rst_inM", 32'(inM), 32'h0);
    chk("rst_ack", 32'(vid_ack), 32'h0);
    chk("rst_vid_data", 32'(vid_data), 32'h0);
    chk("rst_bad", 32'(bad_cnt), 32'h0);

    reset = 1'b1;
    cpu(15'h0000, 1'b1, 16'h0000);
    tick();
    cpu(15'h0010, 1'b1, 16'h1234);
    tick();
    cpu(15'h0010, 1'b0, 16'h0);
    tick();
    chk("ram_rd", 32'(inM), 32'h1234);

    kbd_code = 16'h0041;
    cpu(15'h6000, 1'b0, 16'h0);
    for (int i = 1; i <= K + 1; i++) begin
      tick();
      if (i == K) chk("kbd_early", 32'(inM), 32'h0);
    end
    chk("kbd_rd", 32'(inM), 32'h0041);
    cpu(15'h6000, 1'b1, 16'hFFFF);
    tick();
    cpu(15'h6000, 1'b0, 16'h0);
    tick();
    chk("kbd_wr_drop", 32'(inM), 32'h0041);

    cpu(15'h4005, 1'b1, 16'hAAAA);
    tick();
    cpu(15'h0000, 1'b0, 16'h0);
    vid_req = 1'b1;
    vid_addr = 13'd5;
    tick();
    chk("vid_ack_e1", 32'(vid_ack), 32'h0);
    tick();
    chk("vid_ack_e2", 32'(vid_ack), 32'h1);
    chk("vid_data_e2", 32'(vid_data), 32'hAAAA);
    vid_req = 1'b0;
    tick();
    chk("vid_ack_clr", 32'(vid_ack), 32'h0);
    chk("vid_data_hold", 32'(vid_data), 32'hAAAA);

    cpu(15'h4000, 1'b1, 16'hBEEF);
    tick();
    cpu(15'h4007, 1'b1, 16'h5555);
    tick();
    vid_req = 1'b1;
    vid_addr = 13'd7;
    sawAck = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) cpu(15'h4007, 1'b1, 16'h6666);
      else cpu(15'h4000, 1'b0, 16'h0);
      tick();
      if (vid_ack) sawAck = 1'b1;
    end
    chk("no_ack_cpu_scr", 32'(sawAck), 32'h0);
    chk("cpu_scr_rd", 32'(inM), 32'hBEEF);
    cpu(15'h0000, 1'b0, 16'h0);
    n = 0;
    while (!vid_ack && n < 2) begin
      tick();
      n++;
    end
    chk("ack_after_scr", 32'(vid_ack), 32'h1);
    chk("ack_new_data", 32'(vid_data), 32'h6666);
    vid_req = 1'b0;
    tick();

    vid_addr = 13'd5;
    vid_req = 1'b1;
    tick();
    sawAck = 1'b0;
    cpu(15'h4000, 1'b0, 16'h0);
    repeat (3) begin
      tick();
      if (vid_ack) sawAck = 1'b1;
    end
    chk("reissue_hold", 32'(sawAck), 32'h0);
    cpu(15'h0000, 1'b0, 16'h0);
    n = 0;
    while (!vid_ack && n < 2) begin
      tick();
      n++;
    end
    chk("reissue_ack", 32'(vid_ack), 32'h1);
    chk("reissue_data", 32'(vid_data), 32'hAAAA);
    vid_req = 1'b0;
    tick();

    cpu(15'h7000, 1'b0, 16'h0);
    repeat (10) tick();
    chk("bad_10", 32'(bad_cnt), 32'd10);
    cpu(15'h6001, 1'b1, 16'h1111);
    repeat (300) tick();
    chk("bad_sat", 32'(bad_cnt), 32'd255);
    cpu(15'h0000, 1'b0, 16'h0);
    reset = 1'b0;
    tick();
    chk("bad_rst", 32'(bad_cnt), 32'd0);
    reset = 1'b1;
    cpu(15'h0010, 1'b0, 16'h0);
    tick();
    chk("ram_keep", 32'(inM), 32'h1234);

    cpu(15'h0000, 1'b0, 16'h0);
    vid_addr = 13'd5;
    vid_req = 1'b1;
    tick();
    vid_req = 1'b0;
    sawAck = 1'b0;
    repeat (3) begin
      tick();
      if (vid_ack) sawAck = 1'b1;
    end
    chk("abort_no_ack", 32'(sawAck), 32'h0);
    vid_req = 1'b1;
    tick();
    if (vid_ack) sawAck = 1'b1;
    reset = 1'b0;
    tick();
    if (vid_ack) sawAck = 1'b1;
    reset = 1'b1;
    vid_req = 1'b0;
    repeat (3) begin
      tick();
      if (vid_ack) sawAck = 1'b1;
    end
    chk("rst_abort_no_ack", 32'(sawAck), 32'h0);
    chk("rst_abort_data", 32'(vid_data), 32'h0);
    vid_req = 1'b1;
    n = 0;
    while (!vid_ack && n < 3) begin
      tick();
      n++;
    end
    chk("idle_again_ack", 32'(vid_ack), 32'h1);
    chk("idle_again_data", 32'(vid_data), 32'hAAAA);
    vid_req = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
